ring_sampler: RTL and testbench
===============================

Name: ring_sampler

Overview:
- Parametrised Avalon-ST audio sampler that takes left/right codec sample streams and reduces them to one mono stream.
  - Mode selects left, right, or the average of both.
- Writes samples contiguously into a power-of-two ring buffer that is divided into equal segments.
- Each time a segment completes, pulses go_out to the downstream hannifier with the start segment of the newest full window.
- Flags overrun if the hannifier is still busy when a new window becomes available.

Parameters:
- DATA_W, 16: sample width, both input and ring data.
- ADDR_W, 13: ring buffer address width; ring depth is 2^ADDR_W.
- SEG_LOG2, 10: log2 of segment length; NUM_SEGS = 2^(ADDR_W-SEG_LOG2), 8 by default. Must satisfy SEG_LOG2 < ADDR_W.
- WIN_SEGS, 4: segments per analysis window; 1 <= WIN_SEGS < NUM_SEGS.
- DECIM, 1: decimation factor, used only with SAMPLER_DECIM_EN; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  capture enable.
- mode  in  2  0=left, 1=right, 2=average (L+R)/2, 3=reserved (treated as 0).
- left_in_data  in  DATA_W  left sample, signed.
- left_in_valid  in  1  left valid.
- left_in_ready  out  1  left ready.
- right_in_data  in  DATA_W  right sample, signed.
- right_in_valid  in  1  right valid.
- right_in_ready  out  1  right ready.
- ring_buf_data  out  DATA_W  write data.
- ring_buf_addr  out  ADDR_W  write address.
- ring_buf_wren  out  1  write enable.
- window_start  out  ADDR_W-SEG_LOG2  first segment index of the ready window.
- go_out  out  1  one-cycle window-ready pulse.
- hann_busy  in  1  hannifier still processing the previous window.
- overrun  out  1  sticky overrun flag.

Behaviour:
- Reset values:
  - All outputs 0.
  - Fill counter 0, channel latches empty, decimation counter 0.
- Reset mid-operation discards any partially captured pair and restarts addressing at 0. The ring contents themselves are not cleared.
- Ready rules:
  - left_in_ready = right_in_ready = enable, registered, so ready follows enable with 1 cycle of delay.
  - Both channels are always drained, including the unused channel in mono modes, so the codec never stalls.
  - A transfer occurs on valid && ready.
- Mono modes (mode 0 or 1): each transfer on the selected channel produces one sample.
- Average mode (mode 2):
  - Each channel has a one-entry latch. A transfer fills its channel's latch; a transfer into an already-full latch overwrites it.
  - When both latches are full, including when both fill in the same cycle, produce (sign_ext(L)+sign_ext(R)) >>> 1. The sum is DATA_W+1 bits with an arithmetic shift, so the result is truncated toward minus infinity.
  - Both latches clear in the cycle the sample is produced.
  - A changed mode takes effect at the next produced sample; latches clear on any mode change.
- Write timing:
  - A sample produced in cycle N drives ring_buf_wren=1 with data and address in cycle N+1, all registered.
  - wren is high for exactly one cycle per sample.
  - The address post-increments after each write and wraps from 2^ADDR_W-1 to 0.
- Segment completion:
  - A segment completes on a write whose address low SEG_LOG2 bits are all 1. Let s = address[ADDR_W-1:SEG_LOG2] of that write.
  - The fill counter saturates at WIN_SEGS.
  - If the counter was already >= WIN_SEGS-1 before this completion, then in cycle N+2:
    - go_out=1 for one cycle;
    - window_start = (s-WIN_SEGS+1) mod NUM_SEGS, held until the next go_out.
  - No go_out is issued until WIN_SEGS segments have been filled since reset.
- Overrun:
  - If hann_busy=1 in the go_out cycle, overrun is set and stays set until reset.
  - go_out still fires; the newest window wins.
- enable low stops acceptance only. In-flight writes and go_out still complete.

Optional Feature:
- Macro SAMPLER_DECIM_EN.
- With the macro defined:
  - Only every DECIM-th produced sample is written: the first after reset, then every DECIM-th after it.
  - The counter resets with reset and with mode changes.
- Without the macro: every produced sample is written and DECIM is ignored.

Test Plan:
- Mono left, mode=0, defaults: feed left 0x0001,0x0002,0x0003 on consecutive valids → wren with addr 0,1,2 carrying those data, each 1 cycle after acceptance; right data is never written.
- Average: L=0x7FFF,R=0x7FFF → 0x7FFF; L=0x8000,R=0x8000 → 0x8000; L=0xFFFF,R=0x0000 → 0xFFFF. Cover L arriving 3 cycles before R, and both in the same cycle.
- Window gating: write 4096 samples → no go_out before sample 4095. go_out exactly 1 cycle after the write to addr 4095 with window_start=0. After addr 5119, window_start=1.
- Wrap: write 8192+1024 samples → address wraps 8191→0. go_out after addr 1023 (second lap) with window_start=5.
- Overrun: hann_busy=1 at a go_out → overrun=1 and stays 1. Assert reset mid-segment → all outputs 0, next write at addr 0, and the next go_out only after 4 new segments.
- With SAMPLER_DECIM_EN, DECIM=3: feed 9 samples 1..9 → writes 1,4,7 at addr 0,1,2.

Source files
------------

// File: rtl/ring_sampler.sv
// Stereo-to-mono Avalon-ST sampler feeding a segmented power-of-two ring buffer,
// announcing each newly completed analysis window. Optional decimation via SAMPLER_DECIM_EN.
module ring_sampler #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 13,
  parameter int SEG_LOG2 = 10,
  parameter int WIN_SEGS = 4,
  parameter int DECIM    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic [DATA_W-1:0]            left_in_data,
  input  logic                         left_in_valid,
  output logic                         left_in_ready,
  input  logic [DATA_W-1:0]            right_in_data,
  input  logic                         right_in_valid,
  output logic                         right_in_ready,
  output logic [DATA_W-1:0]            ring_buf_data,
  output logic [ADDR_W-1:0]            ring_buf_addr,
  output logic                         ring_buf_wren,
  output logic [ADDR_W-SEG_LOG2-1:0]   window_start,
  output logic                         go_out,
  input  logic                         hann_busy,
  output logic                         overrun
);

  localparam int SEG_W    = ADDR_W - SEG_LOG2;
  localparam int NUM_SEGS = 1 << SEG_W;
  localparam int FILL_W   = $clog2(WIN_SEGS + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIN_SEGS);
  localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(WIN_SEGS - 1);

  typedef enum logic [1:0] {
    MODE_LEFT  = 2'd0,
    MODE_RIGHT = 2'd1,
    MODE_AVG   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  if (SEG_LOG2 < 1 || SEG_LOG2 >= ADDR_W || WIN_SEGS < 1 || WIN_SEGS >= NUM_SEGS || DECIM < 1)
  begin : g_bad_params
    $error("ring_sampler: illegal parameter combination");
  end

  // ---------------------------------------------------------------------------
  // Input handshake: ready is enable delayed by one cycle, both channels drained.
  // ---------------------------------------------------------------------------
  logic  r_ready;
  logic  w_l_xfer;
  logic  w_r_xfer;
  mode_e w_mode;
  mode_e r_mode_prev;
  logic  w_mode_chg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) r_ready <= 1'b0;
    else       r_ready <= enable;
  end

  assign left_in_ready  = r_ready;
  assign right_in_ready = r_ready;
  assign w_l_xfer       = left_in_valid  & r_ready;
  assign w_r_xfer       = right_in_valid & r_ready;

  assign w_mode     = (mode == MODE_RSVD) ? MODE_LEFT : mode_e'(mode);
  assign w_mode_chg = (w_mode != r_mode_prev);

  // Mode tracking runs through reset so a reset alone never looks like a mode change.
  always_ff @(posedge clk) begin
    r_mode_prev <= w_mode;
  end

  // ---------------------------------------------------------------------------
  // Channel latches and mono sample production.
  // ---------------------------------------------------------------------------
  logic              r_l_full;
  logic              r_r_full;
  logic [DATA_W-1:0] r_l_data;
  logic [DATA_W-1:0] r_r_data;
  logic              w_l_have;
  logic              w_r_have;
  logic [DATA_W-1:0] w_l_val;
  logic [DATA_W-1:0] w_r_val;
  logic [DATA_W:0]   w_sum;
  logic              w_prod;
  logic [DATA_W-1:0] w_sample;
  logic              w_l_full_nx;
  logic              w_r_full_nx;

  assign w_l_have = w_l_xfer | (r_l_full & ~w_mode_chg);
  assign w_r_have = w_r_xfer | (r_r_full & ~w_mode_chg);
  assign w_l_val  = w_l_xfer ? left_in_data  : r_l_data;
  assign w_r_val  = w_r_xfer ? right_in_data : r_r_data;
  assign w_sum    = {w_l_val[DATA_W-1], w_l_val} + {w_r_val[DATA_W-1], w_r_val};

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_prod      = 1'b0;
    w_sample    = '0;
    w_l_full_nx = 1'b0;
    w_r_full_nx = 1'b0;
    case (w_mode)
      MODE_RIGHT: begin
        w_prod   = w_r_xfer;
        w_sample = right_in_data;
      end
      MODE_AVG: begin
        if (w_l_have && w_r_have) begin
          w_prod   = 1'b1;
          w_sample = w_sum[DATA_W:1];
        end else begin
          w_l_full_nx = w_l_have;
          w_r_full_nx = w_r_have;
        end
      end
      default: begin
        w_prod   = w_l_xfer;
        w_sample = left_in_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_l_full <= 1'b0;
      r_r_full <= 1'b0;
    end else begin
      r_l_full <= w_l_full_nx;
      r_r_full <= w_r_full_nx;
    end
  end

  // NOTE: latch payloads need no reset; the full flags alone decide whether
  // they are ever read, which keeps the reset net off the data path.
  always_ff @(posedge clk) begin
    if (w_l_xfer) r_l_data <= left_in_data;
    if (w_r_xfer) r_r_data <= right_in_data;
  end

  // ---------------------------------------------------------------------------
  // Optional decimation: keep the first produced sample, then every DECIM-th.
  // ---------------------------------------------------------------------------
  logic w_keep;
  logic w_write;

`ifdef SAMPLER_DECIM_EN
  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);

  logic [DCNT_W-1:0] r_dcnt;
  logic [DCNT_W-1:0] w_dcnt_base;

  assign w_dcnt_base = w_mode_chg ? '0 : r_dcnt;
  assign w_keep      = (w_dcnt_base == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dcnt <= '0;
    end else if (w_prod) begin
      r_dcnt <= (w_dcnt_base == DCNT_LAST) ? '0 : w_dcnt_base + DCNT_W'(1);
    end else if (w_mode_chg) begin
      r_dcnt <= '0;
    end
  end
`else
  assign w_keep = 1'b1;
`endif

  assign w_write = w_prod & w_keep;

  // ---------------------------------------------------------------------------
  // Ring write port: registered one cycle after production.
  // ---------------------------------------------------------------------------
  logic              r_wren;
  logic [DATA_W-1:0] r_wr_data;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_wr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wren    <= 1'b0;
      r_wr_data <= '0;
      r_wr_addr <= '0;
      r_wr_ptr  <= '0;
    end else begin
      r_wren <= w_write;
      if (w_write) begin
        r_wr_data <= w_sample;
        r_wr_addr <= r_wr_ptr;
        r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
      end
    end
  end

  assign ring_buf_wren = r_wren;
  assign ring_buf_data = r_wr_data;
  assign ring_buf_addr = r_wr_addr;

  // ---------------------------------------------------------------------------
  // Segment tracking, window announcement and overrun.
  // ---------------------------------------------------------------------------
  logic              w_seg_done;
  logic [SEG_W-1:0]  w_seg_idx;
  logic              w_win_ready;
  logic [FILL_W-1:0] r_fill;
  logic              r_go;
  logic [SEG_W-1:0]  r_win_start;
  logic              r_overrun;

  assign w_seg_done  = r_wren & (&r_wr_addr[SEG_LOG2-1:0]);
  assign w_seg_idx   = r_wr_addr[ADDR_W-1:SEG_LOG2];
  assign w_win_ready = w_seg_done & (r_fill >= FILL_THR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill      <= '0;
      r_go        <= 1'b0;
      r_win_start <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_go <= w_win_ready;
      if (w_seg_done && r_fill != FILL_MAX) r_fill <= r_fill + FILL_W'(1);
      // Window start wraps naturally modulo NUM_SEGS in SEG_W bits.
      if (w_win_ready) r_win_start <= w_seg_idx - SEG_W'(WIN_SEGS - 1);
      if (r_go && hann_busy) r_overrun <= 1'b1;
    end
  end

  assign go_out       = r_go;
  assign window_start = r_win_start;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_ring_sampler.sv
// Directed self-checking bench for ring_sampler with default parameters.
module tb_ring_sampler;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 13;
  localparam int SEG_LOG2 = 10;
  localparam int SEG_W    = ADDR_W - SEG_LOG2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic [1:0]          mode = 2'd0;
  logic [DATA_W-1:0]   left_in_data = '0;
  logic                left_in_valid = 1'b0;
  logic                left_in_ready;
  logic [DATA_W-1:0]   right_in_data = '0;
  logic                right_in_valid = 1'b0;
  logic                right_in_ready;
  logic [DATA_W-1:0]   ring_buf_data;
  logic [ADDR_W-1:0]   ring_buf_addr;
  logic                ring_buf_wren;
  logic [SEG_W-1:0]    window_start;
  logic                go_out;
  logic                hann_busy = 1'b0;
  logic                overrun;

  int n_checks = 0;
  int n_fail   = 0;

  ring_sampler dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .mode           (mode),
    .left_in_data   (left_in_data),
    .left_in_valid  (left_in_valid),
    .left_in_ready  (left_in_ready),
    .right_in_data  (right_in_data),
    .right_in_valid (right_in_valid),
    .right_in_ready (right_in_ready),
    .ring_buf_data  (ring_buf_data),
    .ring_buf_addr  (ring_buf_addr),
    .ring_buf_wren  (ring_buf_wren),
    .window_start   (window_start),
    .go_out         (go_out),
    .hann_busy      (hann_busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  // Passive monitor: logs every write and every go pulse with the write seen one cycle earlier.
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_data_q[$];
  int                go_cnt = 0;
  logic [SEG_W-1:0]  go_ws_last = '0;
  logic [ADDR_W-1:0] go_prev_addr = '0;
  logic              go_prev_wren = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic              prev_wren = 1'b0;

  always @(negedge clk) begin
    if (go_out) begin
      go_cnt       = go_cnt + 1;
      go_ws_last   = window_start;
      go_prev_addr = prev_addr;
      go_prev_wren = prev_wren;
    end
    prev_wren = ring_buf_wren;
    prev_addr = ring_buf_addr;
    if (ring_buf_wren) begin
      wr_addr_q.push_back(ring_buf_addr);
      wr_data_q.push_back(ring_buf_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle(input logic lv, input logic [DATA_W-1:0] ld,
                             input logic rv, input logic [DATA_W-1:0] rd);
    left_in_valid  = lv;
    left_in_data   = ld;
    right_in_valid = rv;
    right_in_data  = rd;
    tick();
    left_in_valid  = 1'b0;
    right_in_valid = 1'b0;
  endtask

  task automatic stream_left(input int n, input int first_val);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, DATA_W'(first_val + i), 1'b0, '0);
    tick(); tick(); tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    enable = 1'b1;
    reset  = 1'b1;
    tick(); tick();
    n_checks++; if (ring_buf_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %0b want 0", ring_buf_wren); end
    n_checks++; if (ring_buf_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", ring_buf_addr); end
    n_checks++; if (ring_buf_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", ring_buf_data); end
    n_checks++; if (go_out !== 1'b0) begin n_fail++; $display("FAIL reset_go: got %0b want 0", go_out); end
    n_checks++; if (window_start !== '0) begin n_fail++; $display("FAIL reset_ws: got %0d want 0", window_start); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    n_checks++; if ({left_in_ready, right_in_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {left_in_ready, right_in_ready}); end
    reset = 1'b0;
    tick();
    n_checks++; if ({left_in_ready, right_in_ready} !== 2'b11) begin n_fail++; $display("FAIL ready_follow: got %b want 11", {left_in_ready, right_in_ready}); end
  endtask

  task automatic test_mono_left();
    int base;
    base = wr_data_q.size();
    mode = 2'd0;
    drive_cycle(1'b1, 16'h0001, 1'b1, 16'hAAAA);
    n_checks++; if ({ring_buf_wren, ring_buf_addr, ring_buf_data} !== {1'b1, 13'd0, 16'h0001})
      begin n_fail++; $display("FAIL mono_w0: got wren=%0b addr=%0d data=%h want 1/0/0001", ring_buf_wren, ring_buf_addr, ring_buf_data); end
    drive_cycle(1'b1, 16'h0002, 1'b1, 16'hBBBB);
    n_checks++; if ({ring_buf_wren, ring_buf_addr, ring_buf_data} !== {1'b1, 13'd1, 16'h0002})
      begin n_fail++; $display("FAIL mono_w1: got wren=%0b addr=%0d data=%h want 1/1/0002", ring_buf_wren, ring_buf_addr, ring_buf_data); end
    drive_cycle(1'b1, 16'h0003, 1'b0, '0);
    n_checks++; if ({ring_buf_wren, ring_buf_addr, ring_buf_data} !== {1'b1, 13'd2, 16'h0003})
      begin n_fail++; $display("FAIL mono_w2: got wren=%0b addr=%0d data=%h want 1/2/0003", ring_buf_wren, ring_buf_addr, ring_buf_data); end
    drive_cycle(1'b0, '0, 1'b1, 16'hCCCC);
    n_checks++; if (ring_buf_wren !== 1'b0) begin n_fail++; $display("FAIL mono_idle: got wren=%0b want 0", ring_buf_wren); end
    tick();
    n_checks++; if (wr_data_q.size() - base !== 3) begin n_fail++; $display("FAIL mono_count: got %0d writes want 3", wr_data_q.size() - base); end
  endtask

  task automatic test_average();
    do_reset();
    mode = 2'd2;
    tick();
    drive_cycle(1'b1, 16'h7FFF, 1'b0, '0);
    n_checks++; if (ring_buf_wren !== 1'b0) begin n_fail++; $display("FAIL avg_l_only: got wren=%0b want 0", ring_buf_wren); end
    drive_cycle(1'b0, '0, 1'b0, '0);
    drive_cycle(1'b0, '0, 1'b0, '0);
    n_checks++; if (ring_buf_wren !== 1'b0) begin n_fail++; $display("FAIL avg_wait: got wren=%0b want 0", ring_buf_wren); end
    drive_cycle(1'b0, '0, 1'b1, 16'h7FFF);
    n_checks++; if ({ring_buf_wren, ring_buf_addr, ring_buf_data} !== {1'b1, 13'd0, 16'h7FFF})
      begin n_fail++; $display("FAIL avg_max: got wren=%0b addr=%0d data=%h want 1/0/7fff", ring_buf_wren, ring_buf_addr, ring_buf_data); end
    drive_cycle(1'b1, 16'h8000, 1'b1, 16'h8000);
    n_checks++; if ({ring_buf_wren, ring_buf_addr, ring_buf_data} !== {1'b1, 13'd1, 16'h8000})
      begin n_fail++; $display("FAIL avg_min: got wren=%0b addr=%0d data=%h want 1/1/8000", ring_buf_wren, ring_buf_addr, ring_buf_data); end
    drive_cycle(1'b1, 16'hFFFF, 1'b1, 16'h0000);
    n_checks++; if ({ring_buf_wren, ring_buf_addr, ring_buf_data} !== {1'b1, 13'd2, 16'hFFFF})
      begin n_fail++; $display("FAIL avg_floor: got wren=%0b addr=%0d data=%h want 1/2/ffff", ring_buf_wren, ring_buf_addr, ring_buf_data); end
    // left latch overwritten before right arrives: (0x40 + 0) >>> 1
    drive_cycle(1'b1, 16'h0010, 1'b0, '0);
    drive_cycle(1'b1, 16'h0040, 1'b0, '0);
    drive_cycle(1'b0, '0, 1'b1, 16'h0000);
    n_checks++; if ({ring_buf_wren, ring_buf_addr, ring_buf_data} !== {1'b1, 13'd3, 16'h0020})
      begin n_fail++; $display("FAIL avg_overwrite: got wren=%0b addr=%0d data=%h want 1/3/0020", ring_buf_wren, ring_buf_addr, ring_buf_data); end
    // -3 + 0 = -3, >>> 1 gives -2
    drive_cycle(1'b1, 16'hFFFD, 1'b1, 16'h0000);
    n_checks++; if ({ring_buf_wren, ring_buf_addr, ring_buf_data} !== {1'b1, 13'd4, 16'hFFFE})
      begin n_fail++; $display("FAIL avg_neg_odd: got wren=%0b addr=%0d data=%h want 1/4/fffe", ring_buf_wren, ring_buf_addr, ring_buf_data); end
    // a stale left latch must be dropped by a mode change
    drive_cycle(1'b1, 16'h1234, 1'b0, '0);
    mode = 2'd0;
    tick();
    mode = 2'd2;
    drive_cycle(1'b0, '0, 1'b1, 16'h0002);
    n_checks++; if (ring_buf_wren !== 1'b0) begin n_fail++; $display("FAIL avg_modechg_clear: got wren=%0b want 0", ring_buf_wren); end
    drive_cycle(1'b1, 16'h0006, 1'b0, '0);
    n_checks++; if ({ring_buf_wren, ring_buf_addr, ring_buf_data} !== {1'b1, 13'd5, 16'h0004})
      begin n_fail++; $display("FAIL avg_after_chg: got wren=%0b addr=%0d data=%h want 1/5/0004", ring_buf_wren, ring_buf_addr, ring_buf_data); end
  endtask

  task automatic test_window(output int wr_base, output int go_base);
    do_reset();
    mode = 2'd0;
    tick();
    wr_base = wr_addr_q.size();
    go_base = go_cnt;
    stream_left(4095, 0);
    n_checks++; if (go_cnt - go_base !== 0) begin n_fail++; $display("FAIL win_early_go: got %0d pulses want 0", go_cnt - go_base); end
    stream_left(1, 4095);
    n_checks++; if (go_cnt - go_base !== 1) begin n_fail++; $display("FAIL win_first_go: got %0d pulses want 1", go_cnt - go_base); end
    n_checks++; if ({go_prev_wren, go_prev_addr} !== {1'b1, 13'd4095})
      begin n_fail++; $display("FAIL win_first_timing: got prev wren=%0b addr=%0d want 1/4095", go_prev_wren, go_prev_addr); end
    n_checks++; if (go_ws_last !== 3'd0) begin n_fail++; $display("FAIL win_first_ws: got %0d want 0", go_ws_last); end
    n_checks++; if (window_start !== 3'd0) begin n_fail++; $display("FAIL win_ws_hold: got %0d want 0", window_start); end
    stream_left(1023, 4096);
    n_checks++; if (go_cnt - go_base !== 1) begin n_fail++; $display("FAIL win_mid_go: got %0d pulses want 1", go_cnt - go_base); end
    stream_left(1, 5119);
    n_checks++; if ({go_cnt - go_base, go_prev_addr, go_ws_last} !== {32'd2, 13'd5119, 3'd1})
      begin n_fail++; $display("FAIL win_second: got pulses=%0d addr=%0d ws=%0d want 2/5119/1", go_cnt - go_base, go_prev_addr, go_ws_last); end
  endtask

  task automatic test_wrap(input int wr_base, input int go_base);
    stream_left(4096, 5120);
    n_checks++; if ({go_cnt - go_base, go_prev_addr, go_ws_last} !== {32'd6, 13'd1023, 3'd5})
      begin n_fail++; $display("FAIL wrap_go: got pulses=%0d addr=%0d ws=%0d want 6/1023/5", go_cnt - go_base, go_prev_addr, go_ws_last); end
    n_checks++; if (wr_addr_q.size() - wr_base !== 9216) begin n_fail++; $display("FAIL wrap_count: got %0d writes want 9216", wr_addr_q.size() - wr_base); end
    n_checks++; if ({wr_addr_q[wr_base + 8191], wr_addr_q[wr_base + 8192]} !== {13'd8191, 13'd0})
      begin n_fail++; $display("FAIL wrap_addr: got %0d then %0d want 8191 then 0", wr_addr_q[wr_base + 8191], wr_addr_q[wr_base + 8192]); end
    n_checks++; if (wr_data_q[wr_base + 8192] !== 16'h2000) begin n_fail++; $display("FAIL wrap_data: got %h want 2000", wr_data_q[wr_base + 8192]); end
  endtask

  task automatic test_overrun_reset();
    int go_base;
    int wr_base;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_idle: got %0b want 0", overrun); end
    go_base = go_cnt;
    hann_busy = 1'b1;
    stream_left(1024, 0);
    n_checks++; if ({go_cnt - go_base, go_ws_last} !== {32'd1, 3'd6})
      begin n_fail++; $display("FAIL ovr_go: got pulses=%0d ws=%0d want 1/6", go_cnt - go_base, go_ws_last); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %0b want 1", overrun); end
    hann_busy = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %0b want 1", overrun); end
    stream_left(100, 0);
    mode = 2'd2;
    tick();
    drive_cycle(1'b1, 16'h5555, 1'b0, '0);
    reset = 1'b1;
    tick(); tick();
    n_checks++; if ({ring_buf_wren, ring_buf_addr, ring_buf_data, go_out, window_start, overrun} !== '0)
      begin n_fail++; $display("FAIL midreset_outputs: got wren=%0b addr=%0d data=%h go=%0b ws=%0d ovr=%0b want all 0",
                               ring_buf_wren, ring_buf_addr, ring_buf_data, go_out, window_start, overrun); end
    reset = 1'b0;
    tick();
    drive_cycle(1'b0, '0, 1'b1, 16'h1111);
    n_checks++; if (ring_buf_wren !== 1'b0) begin n_fail++; $display("FAIL midreset_pair_dropped: got wren=%0b want 0", ring_buf_wren); end
    mode = 2'd0;
    tick();
    wr_base = wr_addr_q.size();
    go_base = go_cnt;
    stream_left(4095, 16'h0100);
    n_checks++; if ({wr_addr_q[wr_base], wr_data_q[wr_base]} !== {13'd0, 16'h0100})
      begin n_fail++; $display("FAIL midreset_first: got addr=%0d data=%h want 0/0100", wr_addr_q[wr_base], wr_data_q[wr_base]); end
    n_checks++; if (go_cnt - go_base !== 0) begin n_fail++; $display("FAIL midreset_early_go: got %0d pulses want 0", go_cnt - go_base); end
    stream_left(1, 0);
    n_checks++; if ({go_cnt - go_base, go_prev_addr, go_ws_last} !== {32'd1, 13'd4095, 3'd0})
      begin n_fail++; $display("FAIL midreset_go: got pulses=%0d addr=%0d ws=%0d want 1/4095/0", go_cnt - go_base, go_prev_addr, go_ws_last); end
  endtask

  initial begin
    int wr_base;
    int go_base;
    test_reset();
    test_mono_left();
    test_average();
    test_window(wr_base, go_base);
    test_wrap(wr_base, go_base);
    test_overrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
